m_axis_ppf_serializer: RTL

//  Output end of the 8-channel polyphase filter bank. Captures one 8-channel DFT result frame
//  (8 x 64-bit complex words) on a frame strobe, buffers up to 2 frames (ping-pong), and drives

---
 rtl/ppf_pkg.sv | 20 ++
 rtl/m_axis_ppf_serializer_if.sv | 26 ++
 rtl/ppf_frame_buf.sv | 58 +++++
 rtl/m_axis_ppf_serializer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ppf_pkg.sv
// Shared definitions for the polyphase filter bank output path (serializer and slave-side wrapper).
package ppf_pkg;
   localparam int NUM_CH   = 8;
   localparam int CH_IDX_W = 3;
   localparam int SAMPLE_W = 32;

   typedef struct packed {
      logic [SAMPLE_W-1:0] re;
      logic [SAMPLE_W-1:0] im;
   } cplx_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic logic is_last_ch(input logic [CH_IDX_W-1:0] idx);
      return idx == CH_IDX_W'(NUM_CH - 1);
   endfunction
endpackage

// File: rtl/m_axis_ppf_serializer_if.sv
// AXI-Stream bundle of the PPF serializer; TUSER is present only when M_AXIS_PPF_TUSER_EN is defined.
interface m_axis_ppf_serializer_if #(parameter int TDATA_WIDTH = 64);
   logic [TDATA_WIDTH-1:0] TDATA;
   logic                   TVALID;
   logic                   TLAST;
   logic                   TREADY;
`ifdef M_AXIS_PPF_TUSER_EN
   logic [ppf_pkg::CH_IDX_W-1:0] TUSER;
`endif

   modport master (
      output TDATA, TVALID, TLAST,
`ifdef M_AXIS_PPF_TUSER_EN
      output TUSER,
`endif
      input  TREADY
   );

   modport slave (
      input  TDATA, TVALID, TLAST,
`ifdef M_AXIS_PPF_TUSER_EN
      input  TUSER,
`endif
      output TREADY
   );
endinterface

// File: rtl/ppf_frame_buf.sv
// Two-slot ping-pong frame store with write/read pointers and an occupancy count.
module ppf_frame_buf
   import ppf_pkg::*;
#(
   parameter int W = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [NUM_CH-1:0][W-1:0]  wr_frame,
   input  logic                      rel,
   input  logic                      rd_other,
   input  logic [CH_IDX_W-1:0]       rd_idx,
   output logic [W-1:0]              rd_word,
   output logic [1:0]                count,
   output logic                      full,
   output logic                      empty
);
   logic [W-1:0] mem [2][NUM_CH];
   logic         wr_ptr_r;
   logic         rd_ptr_r;
   logic [1:0]   count_r;

   // Frame storage; a release and a write in the same cycle may target the same slot.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < NUM_CH; c++) begin
            mem[wr_ptr_r][c] <= wr_frame[c];
         end
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (wr_en) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (rel) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({wr_en, rel})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_word = mem[rd_ptr_r ^ rd_other][rd_idx];
   assign count   = count_r;
   assign full    = (count_r == 2'd2);
   assign empty   = (count_r == 2'd0);
endmodule

// File: rtl/m_axis_ppf_serializer.sv
// Serializes buffered 8-channel DFT frames onto an AXI-Stream master, ch0 first, TLAST on ch7.
// Optional macro M_AXIS_PPF_TUSER_EN adds TUSER carrying the channel index of each beat.
module m_axis_ppf_serializer
   import ppf_pkg::*;
#(
   parameter int TDATA_WIDTH = 64,
   parameter bit OVF_STICKY  = 1'b1
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic                   frame_valid_i,
   input  logic [TDATA_WIDTH-1:0] channel0_data_i,
   input  logic [TDATA_WIDTH-1:0] channel1_data_i,
   input  logic [TDATA_WIDTH-1:0] channel2_data_i,
   input  logic [TDATA_WIDTH-1:0] channel3_data_i,
   input  logic [TDATA_WIDTH-1:0] channel4_data_i,
   input  logic [TDATA_WIDTH-1:0] channel5_data_i,
   input  logic [TDATA_WIDTH-1:0] channel6_data_i,
   input  logic [TDATA_WIDTH-1:0] channel7_data_i,
   m_axis_ppf_serializer_if.master axis,
   output logic [1:0]             frames_pending_o,
   output logic                   overflow_o
);
   state_t                          state_r, state_nx;
   logic [CH_IDX_W-1:0]             idx_r, idx_nx;
   logic                            valid_nx, load, rd_other;
   logic                            hs, rel, accept, drop;
   logic [TDATA_WIDTH-1:0]          rd_word;
   logic                            full, empty;
   logic [NUM_CH-1:0][TDATA_WIDTH-1:0] wr_frame;

   assign wr_frame = {channel7_data_i, channel6_data_i, channel5_data_i, channel4_data_i,
                      channel3_data_i, channel2_data_i, channel1_data_i, channel0_data_i};

   ppf_frame_buf #(.W(TDATA_WIDTH)) u_buf (
      .clk      (ACLK),
      .rst_n    (ARESETn),
      .wr_en    (accept),
      .wr_frame (wr_frame),
      .rel      (rel),
      .rd_other (rd_other),
      .rd_idx   (idx_nx),
      .rd_word  (rd_word),
      .count    (frames_pending_o),
      .full     (full),
      .empty    (empty)
   );

   // Next-state, beat sequencing and capture/drop decisions.
   always_comb begin
      state_nx = state_r;
      idx_nx   = idx_r;
      valid_nx = axis.TVALID;
      load     = 1'b0;
      rd_other = 1'b0;
      hs       = axis.TVALID && axis.TREADY;
      rel      = hs && is_last_ch(idx_r);
      accept   = frame_valid_i && (!full || rel);
      drop     = frame_valid_i && !accept;
      case (state_r)
         IDLE: begin
            if (!empty) begin
               state_nx = SEND;
               idx_nx   = '0;
               valid_nx = 1'b1;
               load     = 1'b1;
            end else begin
               valid_nx = 1'b0;
            end
         end
         SEND: begin
            if (rel) begin
               idx_nx = '0;
               // rd_ptr toggles on this edge, so the following frame sits in the other slot
               if (full) begin
                  load     = 1'b1;
                  rd_other = 1'b1;
                  valid_nx = 1'b1;
               end else begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
               end
            end else if (hs) begin
               idx_nx = idx_r + CH_IDX_W'(1);
               load   = 1'b1;
            end else begin
               valid_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = '0;
            valid_nx = 1'b0;
         end
      endcase
   end

   // State, beat index, registered AXIS outputs and overflow flag.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_r     <= IDLE;
         idx_r       <= '0;
         axis.TDATA  <= '0;
         axis.TVALID <= 1'b0;
         axis.TLAST  <= 1'b0;
`ifdef M_AXIS_PPF_TUSER_EN
         axis.TUSER  <= '0;
`endif
         overflow_o  <= 1'b0;
      end else begin
         state_r     <= state_nx;
         idx_r       <= idx_nx;
         axis.TVALID <= valid_nx;
         if (load) begin
            axis.TDATA <= rd_word;
            axis.TLAST <= is_last_ch(idx_nx);
`ifdef M_AXIS_PPF_TUSER_EN
            axis.TUSER <= idx_nx;
`endif
         end else if (!valid_nx) begin
            axis.TLAST <= 1'b0;
         end else begin
            axis.TLAST <= axis.TLAST;
         end
         if (OVF_STICKY) begin
            overflow_o <= overflow_o | drop;
         end else begin
            overflow_o <= drop;
         end
      end
   end
endmodule
